// File: rtl/rx_byte_fifo.sv
// Byte FIFO between a streaming producer and a polled status/data port; empty feeds the status PIO.
// Latency: push visible in level/empty one edge later; popped word registered on the accepting edge.
// Backpressure: wr_ready = !full; writes offered while full are dropped and recorded in sticky overflow.
module rx_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  input  logic              flush
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d;
  logic              empty_w, full_w;
  logic              push_ok, pop_ok;

  // Status decodes only from the level register, never from inputs.
  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LVL_FULL);
  assign push_ok = wr_valid && !full_w && !flush;
  assign pop_ok  = rd_en && !empty_w && !flush;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;

    if (wr_valid && full_w) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (push_ok) begin
        wp_d = wp_q + PTR_ONE;
      end
      if (pop_ok) begin
        rp_d      = rp_q + PTR_ONE;
        rd_data_d = mem_q[rp_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  assign wr_ready = !full_w;
  assign empty    = empty_w;
  assign full     = full_w;
  assign level    = level_q;
  assign rd_data  = rd_data_q;
  assign overflow = ovf_q;

endmodule
